univ_shift_reg: RTL and testbench
=================================

UNIV_SHIFT_REG -- requirements
Module: univ_shift_reg

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, register width in bits (legal range 2..32).
REQ-002 The block SHALL have parameter RESET_VAL, default 0, WIDTH-bit value loaded into q on reset.
REQ-003 The block SHALL use a single clock and an asynchronous, active-low reset.
REQ-004 clk  input  1  rising-edge clock for all state.
REQ-005 reset_n  input  1  asynchronous active-low reset.
REQ-006 en  input  1  clock enable; when 0, no register or FSM state advances except as stated under Reset.
REQ-007 mode  input  3  operation select (see REQ-014).
REQ-008 d  input  WIDTH  parallel load data.
REQ-009 sin_l  input  1  serial input entering the MSB on right shift.
REQ-010 sin_r  input  1  serial input entering the LSB on left shift.
REQ-011 start  input  1  burst request, sampled when en=1.
REQ-012 cnt  input  CW=$clog2(WIDTH+1)  burst operation count.
REQ-013 q  output  WIDTH  register contents; sout_l output 1 = q[WIDTH-1]; sout_r output 1 = q[0]; busy output 1; done output 1; err output 1.

Function
REQ-014 In IDLE with en=1 and start=0, q SHALL update per mode: 000 hold; 001 shift left {q[W-2:0],sin_r}; 010 shift right {sin_l,q[W-1:1]}; 011 rotate left {q[W-2:0],q[W-1]}; 100 rotate right {q[0],q[W-1:1]}; 101 load d; 110 clear to 0 (not RESET_VAL); 111 hold.
REQ-015 FSM states SHALL be IDLE, BURST, DONE.
REQ-016 IDLE, en=1, start=1, mode in 001..100, 1<=cnt<=WIDTH: latch mode and cnt, perform the first operation that same edge, remaining=cnt-1; go to BURST if remaining>0, else DONE.
REQ-017 IDLE, en=1, start=1 with cnt=0, cnt>WIDTH, or mode not in 001..100: q unchanged, state stays IDLE, err=1 for exactly one cycle.
REQ-018 In BURST each edge with en=1 SHALL apply the latched operation once and decrement remaining; at remaining reaching 0 go to DONE.
REQ-019 In BURST, en=0 SHALL stall (q and remaining hold); mode, d, start, cnt SHALL be ignored; sin_l/sin_r sampled live on each burst shift.
REQ-020 DONE SHALL last one cycle regardless of en, hold q, then return to IDLE; start/mode ignored in DONE.
REQ-021 busy SHALL be 1 exactly while state=BURST; done SHALL be 1 exactly while state=DONE; both registered.
REQ-022 A burst of cnt ops SHALL end with done asserted on the cycle after the cnt-th operating edge; with en held 1, done appears cnt cycles after the start edge.
REQ-023 sout_l/sout_r SHALL be combinational from q with zero added latency.
REQ-024 Rotate by cnt=WIDTH SHALL return q to its pre-burst value.

Reset
REQ-025 reset_n=0 SHALL immediately, independent of clk and en, set q=RESET_VAL, state=IDLE, busy=0, done=0, err=0, remaining=0.
REQ-026 Reset asserted mid-burst SHALL abort the burst with no done pulse; after release the block accepts a new start on the first enabled edge.
REQ-027 Deassertion SHALL take effect on the first rising clk edge with reset_n=1.

Verification (WIDTH=8, RESET_VAL=8'hA5 unless noted)
REQ-028 Reset: pulse reset_n low between clk edges with q=8'h3C -> q=8'hA5 immediately, busy=done=err=0.
REQ-029 Manual modes: load d=8'h81, then mode 001 sin_r=1 -> 8'h03; mode 100 -> 8'h81; mode 010 sin_l=0 -> 8'h40; mode 110 -> 8'h00; en=0 any mode -> q holds.
REQ-030 Burst rotate: q=8'h96, start mode=011 cnt=8, en=1 -> busy 7 cycles, done 1 cycle, final q=8'h96; intermediate after 1 op = 8'h2D.
REQ-031 Burst stall: q=8'h01, start mode=001 cnt=3 sin_r=0, en low 2 cycles mid-burst -> q=8'h08 only after 3 enabled edges, done delayed by 2 cycles; mode changes during burst have no effect.
REQ-032 Errors: start with cnt=0, then cnt=9, then mode=101 -> each gives err one cycle, q unchanged, busy never asserted.
REQ-033 Reset mid-burst: start mode=010 cnt=6, assert reset_n after 2 ops -> q=8'hA5, busy=0, no done; new start with cnt=1 after release completes normally.

Source files
------------

// File: rtl/univ_shift_reg_if.sv
// Bundles the control, data and status signals of univ_shift_reg.
// The master side drives controls; the slave side (the register) drives status.
interface univ_shift_reg_if #(
    parameter int WIDTH = 8
) ();
    localparam int CW = $clog2(WIDTH + 1);

    logic             en;
    logic [2:0]       mode;
    logic [WIDTH-1:0] d;
    logic             sin_l;
    logic             sin_r;
    logic             start;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] q;
    logic             sout_l;
    logic             sout_r;
    logic             busy;
    logic             done;
    logic             err;

    modport master (
        output en, mode, d, sin_l, sin_r, start, cnt,
        input  q, sout_l, sout_r, busy, done, err
    );

    modport slave (
        input  en, mode, d, sin_l, sin_r, start, cnt,
        output q, sout_l, sout_r, busy, done, err
    );
endinterface

// File: rtl/univ_shift_reg.sv
// Universal shift register with single-step modes and a counted burst
// of shift/rotate operations sequenced by a small IDLE/BURST/DONE FSM.
module univ_shift_reg #(
    parameter int               WIDTH     = 8,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic            clk,
    input  logic            reset_n,
    univ_shift_reg_if.slave bus
);
    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {IDLE, BURST, DONE} state_t;

    state_t           state, state_nxt;
    logic [WIDTH-1:0] q, q_nxt;
    logic [CW-1:0]    remaining, remaining_nxt;
    logic [2:0]       op_mode, op_mode_nxt;
    logic             busy, busy_nxt;
    logic             done, done_nxt;
    logic             err, err_nxt;
    logic             start_ok;

    function automatic logic [WIDTH-1:0] apply_op(
        input logic [2:0]       op,
        input logic [WIDTH-1:0] cur,
        input logic [WIDTH-1:0] din,
        input logic             sl,
        input logic             sr
    );
        logic [WIDTH-1:0] res;
        case (op)
            3'b001:  res = {cur[WIDTH-2:0], sr};
            3'b010:  res = {sl, cur[WIDTH-1:1]};
            3'b011:  res = {cur[WIDTH-2:0], cur[WIDTH-1]};
            3'b100:  res = {cur[0], cur[WIDTH-1:1]};
            3'b101:  res = din;
            3'b110:  res = '0;
            default: res = cur;
        endcase
        return res;
    endfunction

    // Only shifts and rotates may be bursted, and the count must fit the width.
    assign start_ok = (bus.mode >= 3'b001) && (bus.mode <= 3'b100) &&
                      (bus.cnt != '0) && (bus.cnt <= CW'(WIDTH));

    always_comb begin
        state_nxt     = state;
        q_nxt         = q;
        remaining_nxt = remaining;
        op_mode_nxt   = op_mode;
        err_nxt       = 1'b0;
        case (state)
            IDLE: begin
                if (bus.en) begin
                    if (bus.start) begin
                        if (start_ok) begin
                            q_nxt         = apply_op(bus.mode, q, bus.d, bus.sin_l, bus.sin_r);
                            op_mode_nxt   = bus.mode;
                            remaining_nxt = bus.cnt - CW'(1);
                            state_nxt     = (bus.cnt == CW'(1)) ? DONE : BURST;
                        end else begin
                            err_nxt = 1'b1;
                        end
                    end else begin
                        q_nxt = apply_op(bus.mode, q, bus.d, bus.sin_l, bus.sin_r);
                    end
                end
            end
            BURST: begin
                if (bus.en) begin
                    q_nxt         = apply_op(op_mode, q, bus.d, bus.sin_l, bus.sin_r);
                    remaining_nxt = remaining - CW'(1);
                    if (remaining == CW'(1)) state_nxt = DONE;
                end
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
        busy_nxt = (state_nxt == BURST);
        done_nxt = (state_nxt == DONE);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= IDLE;
            q         <= RESET_VAL;
            remaining <= '0;
            op_mode   <= 3'b000;
            busy      <= 1'b0;
            done      <= 1'b0;
            err       <= 1'b0;
        end else begin
            state     <= state_nxt;
            q         <= q_nxt;
            remaining <= remaining_nxt;
            op_mode   <= op_mode_nxt;
            busy      <= busy_nxt;
            done      <= done_nxt;
            err       <= err_nxt;
        end
    end

    assign bus.q      = q;
    assign bus.sout_l = q[WIDTH-1];
    assign bus.sout_r = q[0];
    assign bus.busy   = busy;
    assign bus.done   = done;
    assign bus.err    = err;
endmodule

// File: tb/tb_univ_shift_reg.sv
// Directed self-checking bench for univ_shift_reg (WIDTH=8, RESET_VAL=8'hA5).
module tb_univ_shift_reg;
    logic clk;
    logic reset_n;
    int   checks;
    int   errors;

    univ_shift_reg_if #(.WIDTH(8)) u_if ();

    univ_shift_reg #(.WIDTH(8), .RESET_VAL(8'hA5)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (u_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_status(input string tag, input logic [7:0] eq, input logic eb,
                              input logic ed, input logic ee);
        chk({tag, ".q"},    {24'd0, u_if.q}, {24'd0, eq});
        chk({tag, ".busy"}, {31'd0, u_if.busy}, {31'd0, eb});
        chk({tag, ".done"}, {31'd0, u_if.done}, {31'd0, ed});
        chk({tag, ".err"},  {31'd0, u_if.err},  {31'd0, ee});
    endtask

    initial begin
        #20000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        checks = 0;
        errors = 0;
        reset_n = 1'b0;
        u_if.en = 1'b0; u_if.mode = 3'b000; u_if.d = 8'h00;
        u_if.sin_l = 1'b0; u_if.sin_r = 1'b0; u_if.start = 1'b0; u_if.cnt = 4'd0;
        #12;
        chk_status("por", 8'hA5, 1'b0, 1'b0, 1'b0);
        reset_n = 1'b1;

        // Asynchronous reset between edges
        u_if.en = 1'b1; u_if.mode = 3'b101; u_if.d = 8'h3C;
        tick();
        chk("load3c", {24'd0, u_if.q}, 32'h3C);
        u_if.en = 1'b0;
        #2 reset_n = 1'b0;
        #1 chk_status("async_rst", 8'hA5, 1'b0, 1'b0, 1'b0);
        #2 reset_n = 1'b1;

        // Manual modes
        u_if.en = 1'b1; u_if.mode = 3'b101; u_if.d = 8'h81;
        tick(); chk("load81", {24'd0, u_if.q}, 32'h81);
        chk("sout_l81", {31'd0, u_if.sout_l}, 32'd1);
        chk("sout_r81", {31'd0, u_if.sout_r}, 32'd1);
        u_if.mode = 3'b001; u_if.sin_r = 1'b1;
        tick(); chk("shl", {24'd0, u_if.q}, 32'h03);
        chk("sout_l03", {31'd0, u_if.sout_l}, 32'd0);
        chk("sout_r03", {31'd0, u_if.sout_r}, 32'd1);
        u_if.mode = 3'b100;
        tick(); chk("rotr", {24'd0, u_if.q}, 32'h81);
        u_if.mode = 3'b010; u_if.sin_l = 1'b0;
        tick(); chk("shr", {24'd0, u_if.q}, 32'h40);
        chk("sout_l40", {31'd0, u_if.sout_l}, 32'd0);
        chk("sout_r40", {31'd0, u_if.sout_r}, 32'd0);
        u_if.mode = 3'b110;
        tick(); chk("clear", {24'd0, u_if.q}, 32'h00);
        u_if.mode = 3'b101; u_if.d = 8'h5A;
        tick(); chk("load5a", {24'd0, u_if.q}, 32'h5A);
        u_if.en = 1'b0; u_if.d = 8'hFF;
        tick(); chk("en0_load", {24'd0, u_if.q}, 32'h5A);
        u_if.mode = 3'b001;
        tick(); chk("en0_shl", {24'd0, u_if.q}, 32'h5A);
        u_if.en = 1'b1; u_if.mode = 3'b000;
        tick(); chk("hold000", {24'd0, u_if.q}, 32'h5A);
        u_if.mode = 3'b111;
        tick(); chk("hold111", {24'd0, u_if.q}, 32'h5A);
        u_if.mode = 3'b011;
        tick(); chk("rotl", {24'd0, u_if.q}, 32'hB4);

        // Burst rotate by WIDTH restores the value
        u_if.mode = 3'b101; u_if.d = 8'h96;
        tick();
        u_if.start = 1'b1; u_if.mode = 3'b011; u_if.cnt = 4'd8;
        tick();
        u_if.start = 1'b0; u_if.mode = 3'b000;
        chk_status("rot_op1", 8'h2D, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 6; i++) begin
            tick();
            chk("rot_busy", {31'd0, u_if.busy}, 32'd1);
        end
        tick(); chk_status("rot_done", 8'h96, 1'b0, 1'b1, 1'b0);
        tick(); chk_status("rot_idle", 8'h96, 1'b0, 1'b0, 1'b0);

        // Burst with stall and mode changes mid-burst
        u_if.mode = 3'b101; u_if.d = 8'h01;
        tick();
        u_if.start = 1'b1; u_if.mode = 3'b001; u_if.cnt = 4'd3; u_if.sin_r = 1'b0;
        tick(); chk_status("stl_op1", 8'h02, 1'b1, 1'b0, 1'b0);
        u_if.start = 1'b0; u_if.mode = 3'b110; u_if.d = 8'hFF; u_if.en = 1'b0;
        tick(); chk_status("stl_hold1", 8'h02, 1'b1, 1'b0, 1'b0);
        tick(); chk_status("stl_hold2", 8'h02, 1'b1, 1'b0, 1'b0);
        u_if.en = 1'b1;
        tick(); chk_status("stl_op2", 8'h04, 1'b1, 1'b0, 1'b0);
        tick(); chk_status("stl_done", 8'h08, 1'b0, 1'b1, 1'b0);
        u_if.mode = 3'b000;
        tick(); chk_status("stl_idle", 8'h08, 1'b0, 1'b0, 1'b0);

        // Illegal start requests
        u_if.start = 1'b1; u_if.mode = 3'b001; u_if.cnt = 4'd0;
        tick(); chk_status("err_cnt0", 8'h08, 1'b0, 1'b0, 1'b1);
        u_if.start = 1'b0; u_if.mode = 3'b000;
        tick(); chk_status("err_clr0", 8'h08, 1'b0, 1'b0, 1'b0);
        u_if.start = 1'b1; u_if.mode = 3'b001; u_if.cnt = 4'd9;
        tick(); chk_status("err_cnt9", 8'h08, 1'b0, 1'b0, 1'b1);
        u_if.mode = 3'b101; u_if.cnt = 4'd3; u_if.d = 8'hFF;
        tick(); chk_status("err_mode", 8'h08, 1'b0, 1'b0, 1'b1);
        u_if.start = 1'b0; u_if.mode = 3'b000;
        tick(); chk_status("err_clr1", 8'h08, 1'b0, 1'b0, 1'b0);

        // Reset mid-burst, then an immediate new burst
        u_if.start = 1'b1; u_if.mode = 3'b010; u_if.cnt = 4'd6; u_if.sin_l = 1'b1;
        tick(); chk_status("rmb_op1", 8'h84, 1'b1, 1'b0, 1'b0);
        u_if.start = 1'b0; u_if.mode = 3'b000;
        tick(); chk_status("rmb_op2", 8'hC2, 1'b1, 1'b0, 1'b0);
        #2 reset_n = 1'b0;
        #1 chk_status("rmb_rst", 8'hA5, 1'b0, 1'b0, 1'b0);
        tick(); chk_status("rmb_held", 8'hA5, 1'b0, 1'b0, 1'b0);
        #2 reset_n = 1'b1;
        u_if.start = 1'b1; u_if.mode = 3'b011; u_if.cnt = 4'd1;
        tick(); chk_status("rmb_new", 8'h4B, 1'b0, 1'b1, 1'b0);
        u_if.start = 1'b0; u_if.mode = 3'b000;
        tick(); chk_status("rmb_end", 8'h4B, 1'b0, 1'b0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
